// File: rtl/map_pkg.sv
// Shared types and constants for the 40x30 maze tile map.
// Tile codes, map geometry, request opcodes and writer FSM states.
package map_pkg;

  localparam logic [5:0]  MAP_W      = 6'd40;
  localparam logic [4:0]  MAP_H      = 5'd30;
  localparam logic [10:0] PELLET_MAX = 11'd2047;

  typedef enum logic [3:0] {
    TILE_EMPTY  = 4'd0,
    TILE_PELLET = 4'd1,
    TILE_POWER  = 4'd2,
    TILE_WALL   = 4'd3
  } tile_t;

  typedef enum logic {
    OP_EAT = 1'b0,
    OP_SET = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CHK,
    WR
  } wr_state_t;

  function automatic logic is_pellet(input logic [3:0] t);
    return (t == TILE_PELLET) || (t == TILE_POWER);
  endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// Combinational tile coordinate to linear RAM address (y*40+x).
// Also flags whether the coordinate lies inside the map.
module tile_addr_calc
  import map_pkg::*;
(
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  output logic [11:0] addr,
  output logic        in_range
);

  logic [11:0] y_ext;
  logic [11:0] x_ext;

  assign y_ext = {7'd0, y};
  assign x_ext = {6'd0, x};

  // y*40 = y*32 + y*8, no multiplier needed
  assign addr     = (y_ext << 5) + (y_ext << 3) + x_ext;
  assign in_range = (x < MAP_W) && (y < MAP_H);

endmodule

// File: rtl/map_tile_writer.sv
// Read-modify-write agent for the maze tile RAM; tracks pellets and score.
// Define MAP_WALL_PROTECT_EN to refuse SET requests that target wall tiles.
module map_tile_writer
  import map_pkg::*;
#(
  parameter int PELLET_PTS = 10,
  parameter int POWER_PTS  = 50
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [5:0]  req_x,
  input  logic [4:0]  req_y,
  input  logic [3:0]  req_data,
  input  logic        load_count,
  input  logic [10:0] load_value,
  output logic [11:0] ram_read_addr,
  input  logic [3:0]  ram_rd_data,
  output logic [11:0] ram_write_addr,
  output logic [3:0]  ram_data_In,
  output logic        ram_we,
  output logic        eat_valid,
  output logic [7:0]  eat_points,
  output logic        power_eaten,
  output logic [10:0] pellets_left,
  output logic        level_clear,
  output logic        req_err
);

  wr_state_t   state, state_nx;
  op_t         op_q;
  logic [3:0]  data_q;
  logic        range_q;
  logic [11:0] calc_addr;
  logic        calc_ok;
  logic        accept;

  logic        do_write;
  logic        do_eat;
  logic        do_pow;
  logic        do_dec;
  logic        do_inc;
  logic        do_err;
  logic        old_pel;
  logic        new_pel;

  tile_addr_calc u_calc (
    .x        (req_x),
    .y        (req_y),
    .addr     (calc_addr),
    .in_range (calc_ok)
  );

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign old_pel   = is_pellet(ram_rd_data);
  assign new_pel   = is_pellet(data_q);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = RD;
      RD:   state_nx = range_q ? CHK : IDLE;
      CHK:  state_nx = WR;
      WR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Decision taken while the old tile is on ram_rd_data
  always_comb begin
    do_write = 1'b0;
    do_eat   = 1'b0;
    do_pow   = 1'b0;
    do_dec   = 1'b0;
    do_inc   = 1'b0;
    do_err   = 1'b0;
    if (state == CHK) begin
      unique case (1'b1)
        (op_q == OP_EAT): begin
          do_write = old_pel;
          do_eat   = old_pel;
          do_pow   = (ram_rd_data == TILE_POWER);
          do_dec   = old_pel;
        end
        default: begin
`ifdef MAP_WALL_PROTECT_EN
          do_err   = (ram_rd_data == TILE_WALL);
          do_write = (ram_rd_data != TILE_WALL);
`else
          do_write = 1'b1;
`endif
          do_dec   = do_write & old_pel & ~new_pel;
          do_inc   = do_write & ~old_pel & new_pel;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      op_q           <= OP_EAT;
      data_q         <= 4'd0;
      range_q        <= 1'b0;
      ram_read_addr  <= 12'd0;
      ram_write_addr <= 12'd0;
      ram_data_In    <= 4'd0;
      ram_we         <= 1'b0;
      eat_valid      <= 1'b0;
      eat_points     <= 8'd0;
      power_eaten    <= 1'b0;
      req_err        <= 1'b0;
    end else begin
      ram_we      <= do_write;
      eat_valid   <= do_eat;
      power_eaten <= do_pow;
      req_err     <= (accept & ~calc_ok) | do_err;
      if (accept) begin
        op_q    <= op_t'(req_op);
        data_q  <= req_data;
        range_q <= calc_ok;
        if (calc_ok) ram_read_addr <= calc_addr;
      end
      if (do_write) begin
        ram_write_addr <= ram_read_addr;
        ram_data_In    <= (op_q == OP_EAT) ? 4'd0 : data_q;
      end
      if (do_eat)
        eat_points <= do_pow ? 8'(POWER_PTS) : 8'(PELLET_PTS);
    end
  end

  // A level load wins over a coincident increment or decrement
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pellets_left <= 11'd0;
      level_clear  <= 1'b0;
    end else begin
      level_clear <= 1'b0;
      if (load_count) begin
        pellets_left <= load_value;
      end else if (do_dec) begin
        if (pellets_left != 11'd0) begin
          pellets_left <= pellets_left - 11'd1;
          level_clear  <= (pellets_left == 11'd1);
        end
      end else if (do_inc) begin
        if (pellets_left != PELLET_MAX)
          pellets_left <= pellets_left + 11'd1;
      end
    end
  end

endmodule
